// File: rtl/cpu_defs.sv
// Shared CPU encodings: branch comparator ops, jump kinds, fetch reset address.
package cpu_defs;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLEZ = 3'b010;
  localparam logic [2:0] BR_BGTZ = 3'b011;
  localparam logic [2:0] BR_BLTZ = 3'b100;
  localparam logic [2:0] BR_BGEZ = 3'b101;
  localparam logic [2:0] BR_BEQ  = 3'b111;

  localparam logic [1:0] J_NONE = 2'b00;
  localparam logic [1:0] J_J    = 2'b01;
  localparam logic [1:0] J_JR   = 2'b10;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

  typedef enum logic {S_RUN = 1'b0, S_HOLD = 1'b1} npc_state_e;

endpackage

// File: rtl/branch_target.sv
// Decodes an ID-stage control transfer and forms its target (branch, j/jal, jr/jalr).
module branch_target
  import cpu_defs::*;
(
  input  logic [31:0] id_pc4_i,
  input  logic [2:0]  br_op_i,
  input  logic        br_i,
  input  logic [1:0]  j_kind_i,
  input  logic [25:0] instr_index_i,
  input  logic [15:0] imm16_i,
  input  logic [31:0] rs_val_i,
  output logic        take_o,
  output logic [31:0] target_o
);

  logic        br_en, j_en;
  logic [31:0] br_tgt;

  assign br_tgt = id_pc4_i + {{14{imm16_i[15]}}, imm16_i, 2'b00};

  always_comb begin
    br_en = 1'b0;
    case (br_op_i)
      BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ, BR_BEQ: br_en = 1'b1;
      default: br_en = 1'b0;
    endcase
    j_en   = (j_kind_i == J_J) || (j_kind_i == J_JR);
    take_o = j_en | (br_en & br_i);
    // A jump outranks a branch decided in the same cycle.
    if (j_kind_i == J_J)       target_o = {id_pc4_i[31:28], instr_index_i, 2'b00};
    else if (j_kind_i == J_JR) target_o = rs_val_i;
    else                       target_o = br_tgt;
  end

endmodule

// File: rtl/npc_ctrl.sv
// IF-stage next-PC controller: sequential fetch, delay-slot redirects, and a held
// redirect while the fetch cannot advance.
module npc_ctrl
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        fetch_ack,
  output logic        fetch_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        id_valid,
  input  logic [31:0] id_pc4,
  input  logic [2:0]  br_op,
  input  logic        br,
  input  logic [1:0]  j_kind,
  input  logic [25:0] instr_index,
  input  logic [15:0] imm16,
  input  logic [31:0] rs_val,
  output logic        redirect,
  output logic        pending
);

  npc_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt_q, tgt_d;
  logic        redirect_q, redirect_d, fetch_req_q;
  logic        take;
  logic [31:0] target;
  logic        advance;

  assign advance = fetch_ack & ~stall;

  branch_target u_tgt (
    .id_pc4_i      (id_pc4),
    .br_op_i       (br_op),
    .br_i          (br),
    .j_kind_i      (j_kind),
    .instr_index_i (instr_index),
    .imm16_i       (imm16),
    .rs_val_i      (rs_val),
    .take_o        (take),
    .target_o      (target)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    redirect_d = 1'b0;
    case (state_q)
      S_RUN: begin
        if (id_valid && take) begin
          if (advance) begin
            pc_d       = target;
            redirect_d = 1'b1;
          end else begin
            tgt_d   = target;
            state_d = S_HOLD;
          end
        end else if (advance) begin
          pc_d = pc_q + 32'd4;
        end
      end
      // A new decision here is a protocol violation; the held target is kept.
      S_HOLD: begin
        if (advance) begin
          pc_d       = tgt_q;
          redirect_d = 1'b1;
          state_d    = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      tgt_q       <= '0;
      redirect_q  <= 1'b0;
      fetch_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      redirect_q  <= redirect_d;
      fetch_req_q <= 1'b1;
    end
  end

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign redirect  = redirect_q;
  assign pending   = (state_q == S_HOLD);
  assign fetch_req = fetch_req_q;

endmodule

// File: doc/npc_ctrl.md
# npc_ctrl

Next-PC controller for the IF stage: the consumer of the ID-stage branch comparator's `br` decision. It owns the fetch PC and computes branch and jump targets with MIPS delay-slot semantics. It sequences the PC against a fetch handshake and against pipeline stalls. When a redirect arrives while the PC cannot advance, the controller holds it pending so that no taken branch is lost.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_3000: fetch address after reset.

Ports (one clock; reset is asynchronous, active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `stall` in 1: hazard-unit freeze; the PC does not advance.
- `fetch_ack` in 1: instruction memory has returned the word at `pc` this cycle.
- `fetch_req` out 1: fetch request for `pc`.
- `pc` out 32: current fetch address.
- `pc_plus4` out 32: `pc + 4`.
- `id_valid` in 1: one-cycle pulse when the ID-stage instruction is decided (the cycle ID advances).
- `id_pc4` in 32: PC+4 of the ID instruction, which is also the delay-slot address.
- `br_op` in 3: comparator op. 000 = none, 001 = bne, 010 = blez, 011 = bgtz, 100 = bltz, 101 = bgez, 111 = beq. 110 is reserved and treated as none.
- `br` in 1: comparator result.
- `j_kind` in 2: 00 = none, 01 = j/jal, 10 = jr/jalr. 11 is treated as none.
- `instr_index` in 26: J-format index.
- `imm16` in 16: branch offset.
- `rs_val` in 32: forwarded rs value for jr/jalr.
- `redirect` out 1: one-cycle pulse when `pc` loads a non-sequential target.
- `pending` out 1: a redirect is held and waiting.

## Operation
- `advance = fetch_ack & ~stall`.
- Target arithmetic, all 32-bit with wrap-around:
  - Branch: `id_pc4 + (sext(imm16) << 2)`.
  - j/jal: `{id_pc4[31:28], instr_index, 2'b00}`.
  - jr/jalr: `rs_val` unmodified. A misaligned target is passed through.
- Redirect taken when `id_valid & (j_kind ∈ {01,10} | (br_op ∉ {000,110} & br))`. If a jump and a branch are both present, the jump target wins.
- FSM with two states:
  - RUN:
    - Taken redirect with `advance`: `pc <- target`, pulse `redirect`, stay in RUN.
    - Taken redirect without `advance`: latch target into `tgt_q`, go to HOLD.
    - Otherwise, on `advance`: `pc <- pc + 4`.
  - HOLD:
    - `pending = 1`.
    - On `advance`: `pc <- tgt_q`, pulse `redirect`, return to RUN.
    - `id_valid` in HOLD is a protocol violation. It is ignored and `tgt_q` is kept.
- Delay slot: at `id_valid`, `pc` equals `id_pc4` (the delay-slot fetch). The target is applied only when that fetch completes. The delay slot is never squashed.
- `fetch_req = 1` whenever out of reset.

## Timing
- Reset values: `pc = RESET_PC`, state = RUN, `tgt_q = 0`, `pending = 0`, `redirect = 0`, `fetch_req = 0`.
- Reset asserted mid-HOLD discards the pending target immediately (asynchronous).
- `fetch_req` rises on the first clock edge after `rst_n` deasserts.
- Redirect latency:
  - Decision at edge N with `advance` high: `pc = target` after edge N.
  - Otherwise: the first edge where `advance` is high.
- `redirect` is registered and high for exactly the cycle after `pc` loads a target.
- `stall` overrides `fetch_ack`: with both high, the PC holds and a HOLD target stays pending.
- `pc_plus4` is combinational from `pc`.

## Structure
- Shared package `cpu_defs`:
  - `BR_NONE`, `BR_BNE`, `BR_BLEZ`, `BR_BGTZ`, `BR_BLTZ`, `BR_BGEZ`, `BR_BEQ` (same encodings as the comparator).
  - `J_NONE`, `J_J`, `J_JR`.
  - Default `RESET_PC`.
- Sub-module `branch_target`: combinational target mux and adder covering the branch, j and jr forms. The FSM, PC register and `tgt_q` stay in `npc_ctrl`.

## Test plan
- Reset, then `fetch_ack = 1` for 3 cycles -> `pc` = 3000, 3004, 3008, 300C; `redirect` stays 0.
- `id_valid`, `br_op = 111`, `br = 1`, `id_pc4 = 3008`, `imm16 = FFFE`, `advance = 1` -> next `pc = 3000`, `redirect` pulses once.
- Same branch but `fetch_ack = 0` for 2 cycles:
  - `pending = 1` and `pc` holds at 3008.
  - On the first ack, `pc = 3000` and `pending = 0`.
- `j_kind = 01`, `instr_index = 0x0000C10`, `id_pc4 = 3010`, with `br_op = 001`, `br = 1` also asserted -> `pc = 00003040` (jump wins).
- `br_op = 010`, `br = 0` -> sequential advance, no redirect.
- Boundary cases:
  - `imm16 = 7FFF` at `id_pc4 = FFFF_FFF0` -> wraps to `0001_FFEC`.
  - `rst_n` low while in HOLD -> `pc = 3000`, `pending = 0` asynchronously.
